ps2_tx: RTL and testbench

PS2_TX -- requirements
Module: ps2_tx

---
 rtl/ps2_pkg.sv | 21 ++
 rtl/ps2_sync.sv | 30 +++
 rtl/ps2_tx.sv | 208 ++++++++++++++++++++
 tb/tb_ps2_tx.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transfer states, start-bit hold time and parity helper.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        START     = 3'd2,
        SEND      = 3'd3,
        ACK       = 3'd4,
        WAIT_IDLE = 3'd5
    } ps2_state_e;

    // Cycles the start bit is driven with the clock still inhibited.
    localparam int START_CYC = 16;

    // PS/2 frames use odd parity: parity bit makes the total count of ones odd.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_sync.sv
// Two-flop synchronizer for one PS/2 pin plus falling-edge detect on the synced level.
module ps2_sync (
    input  logic clk,
    input  logic reset,
    input  logic pin_i,
    output logic level_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Synchronizer chain; idles high because both PS/2 lines are pulled up.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= pin_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level_o = sync_q;
    assign fall_o  = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_tx.sv
// PS/2 host-to-device byte transmitter. Drives open-drain enables only;
// the pad tristates belong to the enclosing top level.
module ps2_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYC = 1600,
    parameter int TIMEOUT_CYC = 32000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [15:0] INH_LAST   = 16'(INHIBIT_CYC - 1);
    localparam logic [15:0] START_LAST = 16'(START_CYC - 1);
    localparam logic [15:0] TO_LAST    = 16'(TIMEOUT_CYC - 1);

    logic       clk_level_s, clk_fall_s;
    logic       dat_level_s, dat_fall_s;

    ps2_state_e state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  data_q, data_d;
    logic        par_q, par_d;
    logic        clk_oe_q, clk_oe_d;
    logic        dat_oe_q, dat_oe_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    ps2_sync u_sync_clk (
        .clk     (clk),
        .reset   (reset),
        .pin_i   (ps2_clk_i),
        .level_o (clk_level_s),
        .fall_o  (clk_fall_s)
    );

    ps2_sync u_sync_dat (
        .clk     (clk),
        .reset   (reset),
        .pin_i   (ps2_dat_i),
        .level_o (dat_level_s),
        .fall_o  (dat_fall_s)
    );

    // State and output registers; reset releases both lines immediately.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 16'd0;
            bit_idx_q <= 4'd0;
            data_q    <= 8'd0;
            par_q     <= 1'b0;
            clk_oe_q  <= 1'b0;
            dat_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            data_q    <= data_d;
            par_q     <= par_d;
            clk_oe_q  <= clk_oe_d;
            dat_oe_q  <= dat_oe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Next-state logic: request, inhibit, start bit, 10 device-clocked bits, ack, bus idle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        data_d    = data_q;
        par_d     = par_q;
        clk_oe_d  = clk_oe_q;
        dat_oe_d  = dat_oe_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;

        case (state_q)
            IDLE: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                if (tx_start) begin
                    data_d   = tx_data;
                    par_d    = odd_parity(tx_data);
                    err_d    = 1'b0;
                    busy_d   = 1'b1;
                    clk_oe_d = 1'b1;
                    cnt_d    = 16'd0;
                    state_d  = INHIBIT;
                end else begin
                    cnt_d = 16'd0;
                end
            end
            INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    cnt_d    = 16'd0;
                    dat_oe_d = 1'b1;
                    state_d  = START;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            START: begin
                if (cnt_q == START_LAST) begin
                    cnt_d     = 16'd0;
                    clk_oe_d  = 1'b0;
                    bit_idx_d = 4'd0;
                    state_d   = SEND;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            SEND: begin
                if (clk_fall_s) begin
                    cnt_d     = 16'd0;
                    bit_idx_d = bit_idx_q + 4'd1;
                    if (bit_idx_q < 4'd8) begin
                        dat_oe_d = ~data_q[bit_idx_q[2:0]];
                    end else if (bit_idx_q == 4'd8) begin
                        dat_oe_d = ~par_q;
                    end else begin
                        dat_oe_d = 1'b0;
                        state_d  = ACK;
                    end
                end else if (cnt_q == TO_LAST) begin
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b0;
                    err_d    = 1'b1;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    cnt_d    = 16'd0;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ACK: begin
                if (clk_fall_s) begin
                    err_d   = dat_level_s;
                    cnt_d   = 16'd0;
                    state_d = WAIT_IDLE;
                end else if (cnt_q == TO_LAST) begin
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b0;
                    err_d    = 1'b1;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    cnt_d    = 16'd0;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            WAIT_IDLE: begin
                if (clk_level_s && dat_level_s) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    cnt_d   = 16'd0;
                    state_d = IDLE;
                end else if (clk_fall_s) begin
                    cnt_d = 16'd0;
                end else if (cnt_q == TO_LAST) begin
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b0;
                    err_d    = 1'b1;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    cnt_d    = 16'd0;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                busy_d   = 1'b0;
                cnt_d    = 16'd0;
                state_d  = IDLE;
            end
        endcase
    end

    assign ps2_clk_oe = clk_oe_q;
    assign ps2_dat_oe = dat_oe_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_ps2_tx.sv
// Bench for ps2_tx: open-drain bus with a behavioural PS/2 device that clocks
// the frame, samples on rising edges and optionally ACKs.
module tb_ps2_tx;

    localparam int INH  = 40;
    localparam int TO   = 600;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       ps2_clk_oe, ps2_dat_oe, busy, done, err;
    logic       dev_clk_low, dev_dat_low;
    logic       clk_line, dat_line;

    assign clk_line = ~(ps2_clk_oe | dev_clk_low);
    assign dat_line = ~(ps2_dat_oe | dev_dat_low);

    ps2_tx #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .ps2_clk_i  (clk_line),
        .ps2_dat_i  (dat_line),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       ack;
        logic       exp_par;
        logic       exp_err;
    } vec_t;

    int   n_cmp = 0;
    int   n_fail = 0;
    int   done_cnt = 0;
    logic err_at_done = 1'b0;

    // Count every done pulse and remember err as seen with it.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt    <= done_cnt + 1;
            err_at_done <= err;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse_start(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    task automatic wait_release(output int ok);
        ok = 0;
        for (int i = 0; i < INH + 100; i++) begin
            if (ps2_clk_oe === 1'b0 && ps2_dat_oe === 1'b1) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Device side of one full frame; returns the 11 line levels it saw.
    task automatic run_frame(input logic [7:0] d, input logic ack,
                             output logic [10:0] fr, output int nd, output logic e);
        int d0;
        int ok;
        d0 = done_cnt;
        fr = '0;
        e  = 1'bx;
        nd = 0;
        pulse_start(d);
        wait_release(ok);
        check("host_release", ok, 1);
        if (ok == 0) return;
        repeat (4) @(negedge clk);
        fr[0] = dat_line;
        for (int k = 1; k <= 10; k++) begin
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
            @(negedge clk);
            fr[k] = dat_line;
        end
        repeat (HALF / 2) @(negedge clk);
        dev_dat_low = ack;
        repeat (HALF / 2) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (HALF) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (HALF / 2) @(negedge clk);
        dev_dat_low = 1'b0;
        for (int i = 0; i < 200 && done_cnt == d0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        nd = done_cnt - d0;
        e  = err_at_done;
    endtask

    task automatic check_frame(input string tag, input logic [7:0] d, input logic par,
                               input logic exp_err, input logic [10:0] fr,
                               input int nd, input logic e);
        check({tag, "_frame"}, {21'd0, fr}, {21'd0, 1'b1, par, d, 1'b0});
        check({tag, "_done_cnt"}, nd, 1);
        check({tag, "_err"}, {31'd0, e}, {31'd0, exp_err});
        check({tag, "_oe_idle"}, {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
        check({tag, "_busy_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        vec_t       vecs [4];
        logic [10:0] fr;
        int         nd;
        logic       e;
        logic [7:0] rd;
        logic       rack;
        logic       rpar;
        int t_clk_rise, t_dat_rise, t_clk_fall, t_done, n_done, n_after;
        logic done_err, done_oe;
        int d0;

        vecs[0] = '{8'hED, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{8'h01, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'hFF, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{8'h3C, 1'b0, 1'b1, 1'b1};

        reset = 1'b1; tx_start = 1'b0; tx_data = 8'd0;
        dev_clk_low = 1'b0; dev_dat_low = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_outputs", {27'd0, ps2_clk_oe, ps2_dat_oe, busy, done, err}, 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Table-driven frames, ending with a NACK.
        for (int i = 0; i < 4; i++) begin
            run_frame(vecs[i].data, vecs[i].ack, fr, nd, e);
            check_frame($sformatf("vec%0d", i), vecs[i].data, vecs[i].exp_par,
                        vecs[i].exp_err, fr, nd, e);
        end
        repeat (10) @(negedge clk);
        check("err_hold", {31'd0, err}, 32'd1);

        // Inhibit/start timing, then a device that never clocks.
        pulse_start(8'hA5);
        check("busy_after_start", {31'd0, busy}, 32'd1);
        check("err_cleared", {31'd0, err}, 32'd0);
        t_clk_rise = -1; t_dat_rise = -1; t_clk_fall = -1; t_done = -1;
        n_done = 0; n_after = 0; done_err = 1'b0; done_oe = 1'b1;
        for (int t = 0; t < INH + 16 + TO + 300; t++) begin
            if (ps2_clk_oe === 1'b1 && t_clk_rise < 0) t_clk_rise = t;
            if (ps2_dat_oe === 1'b1 && t_dat_rise < 0) t_dat_rise = t;
            if (t_clk_rise >= 0 && ps2_clk_oe === 1'b0 && t_clk_fall < 0) t_clk_fall = t;
            if (done === 1'b1) begin
                n_done++;
                if (t_done < 0) begin
                    t_done   = t;
                    done_err = err;
                    done_oe  = ps2_clk_oe | ps2_dat_oe;
                end
            end
            if (t_done >= 0 && t > t_done && (ps2_clk_oe | ps2_dat_oe | busy) === 1'b1) n_after++;
            if (t_clk_fall >= 0 && t == t_clk_fall + 100) begin
                tx_data  = 8'h00;
                tx_start = 1'b1;
            end else begin
                tx_start = 1'b0;
            end
            if (t_done >= 0 && t > t_done + 50) break;
            @(negedge clk);
        end
        tx_start = 1'b0;
        check("inhibit_clk_len", t_clk_fall - t_clk_rise, INH + 16);
        check("start_bit_lead", t_clk_fall - t_dat_rise, 16);
        check("timeout_len", t_done - t_clk_fall, TO);
        check("timeout_err", {31'd0, done_err}, 32'd1);
        check("timeout_oe", {31'd0, done_oe}, 32'd0);
        check("timeout_done_pulses", n_done, 1);
        check("idle_after_timeout", n_after, 0);

        // Reset in the middle of SEND, after the 5th device clock fall.
        pulse_start(8'h8A);
        wait_release(d0);
        check("host_release_rst", d0, 1);
        for (int k = 1; k <= 5; k++) begin
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b1;
            if (k < 5) begin
                repeat (HALF) @(negedge clk);
                dev_clk_low = 1'b0;
            end
        end
        repeat (6) @(negedge clk);
        check("bit4_driven", {31'd0, ps2_dat_oe}, 32'd1);
        d0 = done_cnt;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid_oe", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        dev_clk_low = 1'b0;
        repeat (50) @(negedge clk);
        check("rst_mid_no_done", done_cnt - d0, 0);
        run_frame(8'h55, 1'b1, fr, nd, e);
        check_frame("after_rst", 8'h55, 1'b1, 1'b0, fr, nd, e);

        // Random bytes and ACK/NACK against a frame model built from the byte.
        for (int i = 0; i < 6; i++) begin
            rd   = 8'($urandom_range(0, 255));
            rack = ($urandom_range(0, 3) != 0);
            rpar = (($countones(rd) % 2) == 0);
            run_frame(rd, rack, fr, nd, e);
            check_frame($sformatf("rnd%0d_%02h", i, rd), rd, rpar, ~rack, fr, nd, e);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
